// File: rtl/parity_frame_fsm.sv
// parity_frame_fsm: framed odd/even parity generator over a valid/ready handshake.
// Optional checker built when PARITY_CHECK_EN is defined (adds chk_bit/par_err).
module parity_frame_fsm #(
  parameter int DATA_W = 8,
  parameter int FRAME_LEN = 4,
  localparam int CNT_W = $clog2(FRAME_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              odd,
  input  logic              valid,
  input  logic [DATA_W-1:0] din,
  output logic              in_ready,
  output logic              parity,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic              frame_par,
  output logic              frame_valid,
`ifdef PARITY_CHECK_EN
  input  logic              chk_bit,
  output logic              par_err,
`endif
  input  logic              frame_ready
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  state_t           r_state;
  logic             r_acc, r_mode, r_frame_par, r_frame_valid, r_in_ready;
  logic [CNT_W-1:0] r_cnt;
  logic             w_beat, w_last, w_take, w_start;
  assign w_beat  = ^din;
  assign w_last  = r_cnt == CNT_W'(FRAME_LEN - 1);
  assign w_take  = r_state == HOLD && frame_ready;
  // A load only starts a frame when no finished frame is still waiting to be taken
  assign w_start = load && (r_state != HOLD || frame_ready);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_acc         <= 1'b0;
      r_mode        <= 1'b0;
      r_cnt         <= '0;
      r_frame_par   <= 1'b0;
      r_frame_valid <= 1'b0;
      r_in_ready    <= 1'b0;
    end else if (w_start) begin
      r_state       <= ACCUM;
      r_acc         <= 1'b0;
      r_cnt         <= '0;
      r_mode        <= odd;
      r_frame_valid <= 1'b0;
      r_in_ready    <= 1'b1;
    end else if (r_state == ACCUM && valid) begin
      r_acc <= r_acc ^ w_beat;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_state       <= HOLD;
        r_frame_par   <= r_acc ^ w_beat ^ r_mode;
        r_frame_valid <= 1'b1;
        r_in_ready    <= 1'b0;
      end
    end else if (w_take) begin
      r_state       <= IDLE;
      r_frame_valid <= 1'b0;
    end
  end
`ifdef PARITY_CHECK_EN
  logic r_par_err;
  always_ff @(posedge clk) begin
    if (rst) r_par_err <= 1'b0;
    else if (w_take) r_par_err <= chk_bit != r_frame_par;
    else if (w_start) r_par_err <= 1'b0;
  end
  assign par_err = r_par_err;
`endif
  assign in_ready    = r_in_ready;
  assign parity      = r_acc ^ r_mode;
  assign beat_cnt    = r_cnt;
  assign frame_par   = r_frame_par;
  assign frame_valid = r_frame_valid;
endmodule

// File: tb/tb_parity_frame_fsm.sv
// tb_parity_frame_fsm: scoreboard bench for parity_frame_fsm (DATA_W=8, FRAME_LEN=4).
module tb_parity_frame_fsm;
  logic       clk = 1'b0;
  logic       rst, load, odd, valid, frame_ready, chk_bit;
  logic [7:0] din;
  logic       in_ready, parity, frame_par, frame_valid, par_err;
  logic [2:0] beat_cnt;
  int         checks = 0, errors = 0;
  bit         q_par[$];
  bit         m_acc;
  parity_frame_fsm #(.DATA_W(8), .FRAME_LEN(4)) dut (
    .clk(clk), .rst(rst), .load(load), .odd(odd), .valid(valid), .din(din),
    .in_ready(in_ready), .parity(parity), .beat_cnt(beat_cnt),
    .frame_par(frame_par), .frame_valid(frame_valid),
`ifdef PARITY_CHECK_EN
    .chk_bit(chk_bit), .par_err(par_err),
`endif
    .frame_ready(frame_ready)
  );
`ifndef PARITY_CHECK_EN
  assign par_err = 1'b0;
`endif
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // Scoreboard: every completed frame is popped at its handshake
  always @(negedge clk) begin
    if (!rst && frame_valid && frame_ready) begin
      if (q_par.size() == 0) chk("spurious_frame", 32'(frame_valid), 32'd0);
      else chk("frame_par", 32'(frame_par), 32'(q_par.pop_front()));
    end
  end
  task automatic do_load(input bit o);
    load = 1'b1;
    odd  = o;
    tick();
    load = 1'b0;
    m_acc = o;
    chk("load_cnt", 32'(beat_cnt), 32'd0);
    chk("load_par", 32'(parity), 32'(o));
    chk("load_rdy", 32'(in_ready), 32'd1);
  endtask
  task automatic do_beats(input logic [31:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      chk("beat_rdy", 32'(in_ready), 32'd1);
      valid = 1'b1;
      din   = b[8*i +: 8];
      tick();
      m_acc ^= ^b[8*i +: 8];
      chk("run_par", 32'(parity), 32'(m_acc));
      chk("run_cnt", 32'(beat_cnt), 32'(i + 1));
    end
    valid = 1'b0;
    if (n == 4) begin
      chk("fv_set", 32'(frame_valid), 32'd1);
      chk("hold_rdy", 32'(in_ready), 32'd0);
      q_par.push_back(m_acc);
    end
  endtask
  task automatic handshake(input bit c);
    chk_bit     = c;
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    chk("fv_clr", 32'(frame_valid), 32'd0);
    chk("idle_rdy", 32'(in_ready), 32'd0);
  endtask
  initial begin
    logic [31:0] beats = 32'h07030001;
    rst = 1'b1; load = 1'b0; odd = 1'b0; valid = 1'b0; din = '0;
    frame_ready = 1'b0; chk_bit = 1'b0;
    tick(); tick();
    chk("rst_par", 32'(parity), 32'd0);
    chk("rst_fv", 32'(frame_valid), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd0);
    chk("rst_cnt", 32'(beat_cnt), 32'd0);
    rst = 1'b0;
    tick();
    do_load(1'b1); do_beats(beats, 4);
    chk("odd_fpar", 32'(frame_par), 32'd1);
    handshake(1'b1);
    do_load(1'b0); do_beats(beats, 4);
    chk("even_fpar", 32'(frame_par), 32'd0);
    handshake(1'b0);
    do_load(1'b1); do_beats(32'h5A3C1180, 4);
    valid = 1'b1; din = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      load = (i == 2);
      tick();
      chk("bp_fpar", 32'(frame_par), 32'(m_acc));
      chk("bp_cnt", 32'(beat_cnt), 32'd4);
      chk("bp_rdy", 32'(in_ready), 32'd0);
      chk("bp_fv", 32'(frame_valid), 32'd1);
    end
    load = 1'b0; valid = 1'b0;
    // Back-to-back: take the pending frame and start the next on the same edge
    frame_ready = 1'b1; load = 1'b1; odd = 1'b0;
    tick();
    frame_ready = 1'b0; load = 1'b0; m_acc = 1'b0;
    chk("b2b_fv", 32'(frame_valid), 32'd0);
    chk("b2b_rdy", 32'(in_ready), 32'd1);
    chk("b2b_cnt", 32'(beat_cnt), 32'd0);
    do_beats(32'h01FE7F10, 4);
    handshake(1'b0);
    do_load(1'b1); do_beats(32'h00000301, 2);
    valid = 1'b1; din = 8'h01;
    do_load(1'b0);
    valid = 1'b0;
    do_beats(32'h80402010, 4);
    handshake(1'b0);
    do_load(1'b1); do_beats(32'h00070301, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_par", 32'(parity), 32'd0);
    chk("mrst_cnt", 32'(beat_cnt), 32'd0);
    chk("mrst_rdy", 32'(in_ready), 32'd0);
    frame_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mrst_fv", 32'(frame_valid), 32'd0);
    end
    frame_ready = 1'b0;
`ifdef PARITY_CHECK_EN
    do_load(1'b1); do_beats(beats, 4);
    handshake(1'b0);
    chk("perr_set", 32'(par_err), 32'd1);
    tick(); tick();
    chk("perr_hold", 32'(par_err), 32'd1);
    do_load(1'b1);
    chk("perr_clr", 32'(par_err), 32'd0);
    do_beats(beats, 4);
    handshake(1'b1);
    chk("perr_ok", 32'(par_err), 32'd0);
`endif
    tick();
    chk("sb_empty", 32'(q_par.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
